// File: rtl/regfile_wport_arbiter_if.sv
// Writeback request channels and regfile write-port strobes shared by the
// arbiter (slave) and the writeback sources / regfile side (master).
interface regfile_wport_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic              grant_id;
  logic              init_done;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  we3, wa3, wd3, grant_id, init_done
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output we3, wa3, wd3, grant_id, init_done
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Owns the regfile write port: zeroes X0..X30 after reset, then round-robins
// the port between the ALU (req0) and load (req1) writeback requesters.
module regfile_wport_arbiter #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wport_arbiter_if.slave bus
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(30);
  localparam logic [ADDR_W-1:0] XZR      = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              last_grant_q;
  logic              we3_q;
  logic [ADDR_W-1:0] wa3_q;
  logic [DATA_W-1:0] wd3_q;
  logic              grant_id_q;
  logic              init_done_q;

  logic              rdy0_d;
  logic              rdy1_d;
  logic              hs_d;
  logic              gnt_src_d;
  logic [ADDR_W-1:0] gnt_addr_d;
  logic [DATA_W-1:0] gnt_data_d;

  // On a tie the requester that did not win last time is accepted.
  always_comb begin
    rdy0_d = 1'b0;
    rdy1_d = 1'b0;
    if (!reset && state_q == RUN) begin
      if (bus.req0_valid && bus.req1_valid) begin
        rdy0_d = last_grant_q;
        rdy1_d = !last_grant_q;
      end else begin
        rdy0_d = bus.req0_valid;
        rdy1_d = bus.req1_valid;
      end
    end
    hs_d       = rdy0_d | rdy1_d;
    gnt_src_d  = rdy1_d;
    gnt_addr_d = rdy1_d ? bus.req1_addr : bus.req0_addr;
    gnt_data_d = rdy1_d ? bus.req1_data : bus.req0_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR_ON_RESET ? INIT : RUN;
      init_done_q  <= !CLEAR_ON_RESET;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      we3_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
      grant_id_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          we3_q <= 1'b1;
          wa3_q <= cnt_q;
          wd3_q <= '0;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CLR) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (hs_d) begin
            grant_id_q   <= gnt_src_d;
            last_grant_q <= gnt_src_d;
          end
          // XZR grants complete the handshake but never strobe the port.
          if (hs_d && gnt_addr_d != XZR) begin
            we3_q <= 1'b1;
            wa3_q <= gnt_addr_d;
            wd3_q <= gnt_data_d;
          end else begin
            we3_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.req0_ready = rdy0_d;
  assign bus.req1_ready = rdy1_d;
  assign bus.we3        = we3_q;
  assign bus.wa3        = wa3_q;
  assign bus.wd3        = wd3_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scoreboard bench: a cycle-level request model pushes expected write strobes,
// a negedge monitor pops and compares them, and a shadow regfile is audited.
module tb_regfile_wport_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wport_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  regfile_wport_arbiter #(.DATA_W(64), .ADDR_W(5), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int unsigned  due;
    logic         src;
    logic         clr;
    logic [4:0]   addr;
    logic [63:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  logic [63:0] rf     [32];
  logic [63:0] m_regs [32];
  logic        m_last;
  int unsigned run_from;

  logic        p0v, p1v;
  logic [4:0]  p0a, p1a;
  logic [63:0] p0d, p1d;

  always @(posedge clk) cyc <= cyc + 1;

  // Shadow regfile starts with garbage so the clear sequence is observable.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 31; i++) rf[i] <= 64'hBAD0_0000_0000_0000 | 64'(i);
      rf[31] <= '0;
    end else if (bus.we3 === 1'b1) begin
      rf[bus.wa3] <= bus.wd3;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      check("we3", 64'(bus.we3), 64'd1);
      check("wa3", 64'(bus.wa3), 64'(mon_e.addr));
      check("wd3", bus.wd3, mon_e.data);
      if (mon_e.clr) check("init_done_clr", 64'(bus.init_done), 64'(mon_e.addr == 5'd30));
      else           check("grant_id", 64'(bus.grant_id), 64'(mon_e.src));
    end else begin
      check("we3_idle", 64'(bus.we3), 64'd0);
    end
  end

  task automatic push_exp(input int unsigned due, input logic src, input logic clr,
                          input logic [4:0] addr, input logic [63:0] data);
    exp_t e;
    e.due = due; e.src = src; e.clr = clr; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // Entered and left at posedge+1.
  task automatic do_reset(input int unsigned n);
    int unsigned r;
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready0", 64'(bus.req0_ready), 64'd0);
    check("rst_ready1", 64'(bus.req1_ready), 64'd0);
    #1 exp_q.delete();
    for (int unsigned i = 1; i < n; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_ready0", 64'(bus.req0_ready), 64'd0);
      check("rst_ready1", 64'(bus.req1_ready), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    r = cyc;
    for (int i = 0; i < 31; i++) begin
      push_exp(r + 1 + i, 1'b0, 1'b1, 5'(i), 64'd0);
      m_regs[i] = '0;
    end
    m_last   = 1'b1;
    run_from = r + 31;
  endtask

  // One cycle: present pending requests, predict ready, book the write.
  task automatic step();
    logic run, e0, e1, src;
    logic [4:0] a;
    logic [63:0] d;
    bus.req0_valid = p0v;
    bus.req0_addr  = p0v ? p0a : 5'($urandom);
    bus.req0_data  = p0v ? p0d : {$urandom, $urandom};
    bus.req1_valid = p1v;
    bus.req1_addr  = p1v ? p1a : 5'($urandom);
    bus.req1_data  = p1v ? p1d : {$urandom, $urandom};
    @(negedge clk);
    run = (cyc >= run_from);
    e0 = 1'b0; e1 = 1'b0;
    if (run) begin
      if (p0v && p1v) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = p0v;
        e1 = p1v;
      end
    end
    check("req0_ready", 64'(bus.req0_ready), 64'(e0));
    check("req1_ready", 64'(bus.req1_ready), 64'(e1));
    check("init_done", 64'(bus.init_done), 64'(run));
    if (e0 || e1) begin
      src = e1;
      a = src ? p1a : p0a;
      d = src ? p1d : p0d;
      if (a != 5'd31) begin
        push_exp(cyc + 1, src, 1'b0, a, d);
        m_regs[a] = d;
      end
      m_last = src;
      if (src) p1v = 1'b0; else p0v = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 32; i++) check($sformatf("X%0d", i), rf[i], m_regs[i]);
  endtask

  task automatic fill_random();
    if (!p0v && $urandom_range(0, 9) < 6) begin
      p0v = 1'b1;
      p0a = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      p0d = {$urandom, $urandom};
    end
    if (!p1v && $urandom_range(0, 9) < 6) begin
      p1v = 1'b1;
      p1a = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      p1d = {$urandom, $urandom};
    end
  endtask

  initial begin
    reset = 1'b1;
    p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    m_last = 1'b1;
    run_from = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    @(posedge clk); #1;
    do_reset(2);

    // Clear sequence, then quiet port.
    repeat (36) step();
    check_regs();

    // Lone ALU write.
    p0v = 1'b1; p0a = 5'd5; p0d = 64'hDEAD_BEEF;
    repeat (3) step();

    // Load write to XZR is accepted and dropped.
    p1v = 1'b1; p1a = 5'd31; p1d = 64'hFF;
    repeat (3) step();
    check_regs();

    // Both requesters hammering the port.
    for (int i = 0; i < 4; i++) begin
      if (!p0v) begin p0v = 1'b1; p0a = 5'd1; p0d = 64'hAAAA_0000 + 64'(i); end
      if (!p1v) begin p1v = 1'b1; p1a = 5'd2; p1d = 64'hBBBB_0000 + 64'(i); end
      step();
    end
    repeat (3) step();
    p1v = 1'b1; p1a = 5'd3; p1d = 64'h33;
    step();

    // Same destination from both sides; later grantee wins.
    p0v = 1'b1; p0a = 5'd7; p0d = 64'd1;
    p1v = 1'b1; p1a = 5'd7; p1d = 64'd2;
    repeat (4) step();
    check_regs();

    // Reset in the middle of the clear sequence.
    do_reset(2);
    repeat (12) step();
    do_reset(1);
    repeat (34) step();
    check_regs();

    // Random traffic with a reset landing on a live handshake.
    for (int i = 0; i < 400; i++) begin
      fill_random();
      if (i == 200) begin
        if (!p0v) begin p0v = 1'b1; p0a = 5'd9; p0d = 64'h99; end
        do_reset(2);
      end
      step();
    end
    repeat (40) step();
    check_regs();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
